// File: rtl/shru_restore_unit_pkg.sv
// Shared frame-layout definitions for the shadow-register save and restore paths.
// Both paths import this package so they agree on slot order and the GPR set.
package shru_restore_unit_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned VLEN        = 64;
    localparam int unsigned NrFrameRegs = 16;
    localparam int unsigned NrSlots     = NrFrameRegs + 2;
    localparam int unsigned FrameBytes  = NrSlots * XLEN / 8;
    localparam int unsigned SlotShift   = $clog2(XLEN / 8);

    // x1, x5-x7, x10-x17, x28-x31
    localparam logic [31:0] SHRU_FRAME_GPR_MASK = 32'hF003_FCE2;

    typedef enum logic [4:0] {
        SLOT_MEPC     = 5'd0,
        SLOT_MCAUSE   = 5'd1,
        SLOT_GPR_BASE = 5'd2
    } shru_frame_slot_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } shru_state_e;

    // Frame slot to GPR index; GPR slots hold the frame registers in ascending order.
    // Out-of-range slots map to x1 so the result is never x0.
    function automatic logic [4:0] shru_slot2gpr(input logic [4:0] slot);
        logic [4:0] g;
        g = slot - 5'(SLOT_GPR_BASE);
        if (g == 5'd0) begin
            return 5'd1;
        end else if (g <= 5'd3) begin
            return g + 5'd4;
        end else if (g <= 5'd11) begin
            return g + 5'd6;
        end else if (g <= 5'd15) begin
            return g + 5'd16;
        end else begin
            return 5'd1;
        end
    endfunction

endpackage

// File: rtl/shru_restore_unit.sv
// Restores an mret interrupt frame (mepc, mcause, caller-saved GPRs) from the dcache
// into the CSR shadow registers and the GPR file, one load outstanding at a time.
module shru_restore_unit
    import shru_restore_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            mret_valid_i,
    output logic            mret_ready_o,
    input  logic [VLEN-1:0] frame_sp_i,
    output logic            mem_req_o,
    output logic [VLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            gpr_we_o,
    output logic [4:0]      gpr_waddr_o,
    output logic [XLEN-1:0] gpr_wdata_o,
    output logic            csr_we_o,
    output logic            csr_sel_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic [31:0]     pending_o,
    output logic [4:0]      load_level_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [1:0]      dbg_state_o
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both high.
    // mret_valid_i/mret_ready_o and mem_req_o/mem_gnt_i follow this; mem_req_o and
    // mem_addr_o hold steady until granted, and mem_rvalid_i needs no ready.

    shru_state_e     state_q, state_d;
    logic [4:0]      slot_q, slot_d;
    logic [VLEN-1:0] base_q, base_d;
    logic [31:0]     pending_q, pending_d;
    logic [4:0]      level_q, level_d;

    logic [4:0]      gpr_idx;
    logic [31:0]     clr_mask;
    logic [VLEN-1:0] slot_off;
    logic            last_slot;

    assign gpr_idx   = shru_slot2gpr(slot_q);
    assign slot_off  = VLEN'(slot_q) << SlotShift;
    assign last_slot = (slot_q == 5'(NrSlots - 1));

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        base_d       = base_q;
        pending_d    = pending_q;
        level_d      = level_q;
        mret_ready_o = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        gpr_we_o     = 1'b0;
        gpr_waddr_o  = '0;
        gpr_wdata_o  = '0;
        csr_we_o     = 1'b0;
        csr_sel_o    = 1'b0;
        csr_wdata_o  = '0;
        done_o       = 1'b0;
        clr_mask     = '0;

        unique case (state_q)
            ST_IDLE: begin
                // rst_ni keeps ready low while reset is asserted
                mret_ready_o = ~flush_i & rst_ni;
                if (mret_valid_i && mret_ready_o) begin
                    base_d    = frame_sp_i;
                    slot_d    = '0;
                    pending_d = SHRU_FRAME_GPR_MASK;
                    level_d   = 5'(NrSlots);
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush_i) begin
                    pending_d = '0;
                    level_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = base_q + slot_off;
                    if (mem_gnt_i) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    pending_d = '0;
                    level_d   = '0;
                    state_d   = mem_rvalid_i ? ST_IDLE : ST_DRAIN;
                end else if (mem_rvalid_i) begin
                    if (slot_q < 5'(SLOT_GPR_BASE)) begin
                        csr_we_o    = 1'b1;
                        csr_sel_o   = slot_q[0];
                        csr_wdata_o = mem_rdata_i;
                    end else begin
                        gpr_we_o    = 1'b1;
                        gpr_waddr_o = gpr_idx;
                        gpr_wdata_o = mem_rdata_i;
                        clr_mask    = 32'd1 << gpr_idx;
                        pending_d   = pending_q & ~clr_mask;
                    end
                    level_d = level_q - 5'd1;
                    if (last_slot) begin
                        done_o  = 1'b1;
                        slot_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        slot_d  = slot_q + 5'd1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            base_q    <= '0;
            pending_q <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            base_q    <= base_d;
            pending_q <= pending_d;
            level_q   <= level_d;
        end
    end

    // A register being written this cycle is already visible as restored to issue.
    assign pending_o    = pending_q & ~clr_mask;
    assign load_level_o = level_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_shru_restore_unit.sv
// Directed bench for shru_restore_unit: memory responder, write monitor and
// vector tables of expected restore results and idle-handshake behaviour.
module tb_shru_restore_unit;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        mret_valid_i;
    logic        mret_ready_o;
    logic [63:0] frame_sp_i;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        gpr_we_o;
    logic [4:0]  gpr_waddr_o;
    logic [63:0] gpr_wdata_o;
    logic        csr_we_o;
    logic        csr_sel_o;
    logic [63:0] csr_wdata_o;
    logic [31:0] pending_o;
    logic [4:0]  load_level_o;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  dbg_state_o;

    shru_restore_unit dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .mret_valid_i (mret_valid_i),
        .mret_ready_o (mret_ready_o),
        .frame_sp_i   (frame_sp_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .gpr_we_o     (gpr_we_o),
        .gpr_waddr_o  (gpr_waddr_o),
        .gpr_wdata_o  (gpr_wdata_o),
        .csr_we_o     (csr_we_o),
        .csr_sel_o    (csr_sel_o),
        .csr_wdata_o  (csr_wdata_o),
        .pending_o    (pending_o),
        .load_level_o (load_level_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .dbg_state_o  (dbg_state_o)
    );

    typedef struct packed {
        logic        is_csr;
        logic [4:0]  idx;
        logic [63:0] data;
    } restore_vec_t;

    typedef struct packed {
        logic flush;
        logic mret;
        logic exp_ready;
        logic exp_busy;
    } idle_vec_t;

    restore_vec_t rtab[18];
    idle_vec_t    itab[3];

    int checks = 0;
    int errors = 0;

    // responder controls
    logic [63:0] base_v = '0;
    logic [63:0] data_base = 64'h100;
    int stall_slot = -1;
    int stall_left = 0;
    int lat_slot = -1;
    int lat_val = 1;
    int rsp_cnt = 0;
    logic [63:0] rsp_data = '0;

    // monitor state
    logic [63:0] gpr_got[32];
    logic [63:0] csr_got[2];
    int wr_cnt = 0;
    int csr_cnt = 0;
    int gnt_cnt = 0;
    int x0_wr = 0;

    // per-run tracking
    int s3_first, s3_last, s3_cnt, viol;

    logic any_out;
    assign any_out = |{mret_ready_o, mem_req_o, mem_addr_o, gpr_we_o, gpr_waddr_o, gpr_wdata_o,
                       csr_we_o, csr_sel_o, csr_wdata_o, pending_o, load_level_o, busy_o,
                       done_o, dbg_state_o};

    // clock / reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // memory responder: grants a request unless stalled, answers after a latency
    initial begin
        int slot;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #2;
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
            if (!rst_ni) begin
                rsp_cnt = 0;
            end else if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i = rsp_data;
                end
            end else if (mem_req_o) begin
                slot = int'((mem_addr_o - base_v) >> 3);
                if (slot == stall_slot && stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_gnt_i = 1'b1;
                    rsp_data = data_base + 64'(slot);
                    rsp_cnt = (slot == lat_slot) ? lat_val : 1;
                end
            end
        end
    end

    // write monitor
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (gpr_we_o) begin
                gpr_got[gpr_waddr_o] = gpr_wdata_o;
                wr_cnt++;
                if (gpr_waddr_o == 5'd0) x0_wr++;
            end
            if (csr_we_o) begin
                csr_got[csr_sel_o] = csr_wdata_o;
                csr_cnt++;
            end
            if (mem_req_o && mem_gnt_i) gnt_cnt++;
        end
    end

    task automatic start_restore(input logic [63:0] sp);
        base_v = sp;
        @(posedge clk_i);
        #1;
        mret_valid_i = 1'b1;
        frame_sp_i = sp;
        @(negedge clk_i);
        chk("hs_ready", 64'(mret_ready_o), 64'd1);
    endtask

    task automatic run_restore(input logic [63:0] sp, input bit hold_mret,
                               output int cyc, output logic [63:0] first_addr);
        bit done;
        bit got_first;
        done = 0;
        got_first = 0;
        first_addr = '0;
        cyc = 0;
        s3_first = -1;
        s3_last = -1;
        s3_cnt = 0;
        viol = 0;
        start_restore(sp);
        while (!done && cyc < 200) begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (!hold_mret) mret_valid_i = 1'b0;
            @(negedge clk_i);
            if (cyc == 1) begin
                chk("start_level", 64'(load_level_o), 64'd18);
                chk("start_pending", 64'(pending_o), 64'hF003_FCE2);
            end
            if (busy_o && mret_ready_o) viol++;
            if (mem_req_o && !got_first) begin
                got_first = 1;
                first_addr = mem_addr_o;
            end
            if (gpr_we_o && gpr_waddr_o == 5'd10) begin
                chk("pending_after_x10", 64'(pending_o), 64'hF003_F800);
                chk("level_after_x10", 64'(load_level_o), 64'd12);
            end
            if (mem_req_o && mem_addr_o == sp + 64'h18) begin
                if (s3_first < 0) s3_first = cyc;
                s3_last = cyc;
                s3_cnt++;
            end
            if (done_o) done = 1;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("ready_while_busy", 64'(viol), 64'd0);
        @(posedge clk_i);
        #1;
        mret_valid_i = 1'b0;
        @(negedge clk_i);
        chk("end_busy", 64'(busy_o), 64'd0);
        chk("end_done_low", 64'(done_o), 64'd0);
        chk("end_pending", 64'(pending_o), 64'd0);
        chk("end_level", 64'(load_level_o), 64'd0);
    endtask

    task automatic find_grant(input logic [63:0] addr, output bit found);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk_i);
            #1;
            mret_valid_i = 1'b0;
            @(negedge clk_i);
            if (mem_req_o && mem_gnt_i && mem_addr_o == addr) found = 1;
        end
    endtask

    initial begin
        int cyc;
        int wr0, csr0, gnt0;
        bit found;
        logic [63:0] first_addr;

        rtab[0]  = '{1'b1, 5'd0,  64'h100};
        rtab[1]  = '{1'b1, 5'd1,  64'h101};
        rtab[2]  = '{1'b0, 5'd1,  64'h102};
        rtab[3]  = '{1'b0, 5'd5,  64'h103};
        rtab[4]  = '{1'b0, 5'd6,  64'h104};
        rtab[5]  = '{1'b0, 5'd7,  64'h105};
        rtab[6]  = '{1'b0, 5'd10, 64'h106};
        rtab[7]  = '{1'b0, 5'd11, 64'h107};
        rtab[8]  = '{1'b0, 5'd12, 64'h108};
        rtab[9]  = '{1'b0, 5'd13, 64'h109};
        rtab[10] = '{1'b0, 5'd14, 64'h10A};
        rtab[11] = '{1'b0, 5'd15, 64'h10B};
        rtab[12] = '{1'b0, 5'd16, 64'h10C};
        rtab[13] = '{1'b0, 5'd17, 64'h10D};
        rtab[14] = '{1'b0, 5'd28, 64'h10E};
        rtab[15] = '{1'b0, 5'd29, 64'h10F};
        rtab[16] = '{1'b0, 5'd30, 64'h110};
        rtab[17] = '{1'b0, 5'd31, 64'h111};

        itab[0] = '{1'b0, 1'b0, 1'b1, 1'b0};
        itab[1] = '{1'b1, 1'b0, 1'b0, 1'b0};
        itab[2] = '{1'b1, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 32; i++) gpr_got[i] = '0;
        csr_got[0] = '0;
        csr_got[1] = '0;

        rst_ni = 1'b0;
        flush_i = 1'b0;
        mret_valid_i = 1'b0;
        frame_sp_i = 64'h8000_1000;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_outputs", 64'(any_out), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_after_reset_ready", 64'(mret_ready_o), 64'd1);

        // idle handshake vectors
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            flush_i = itab[i].flush;
            mret_valid_i = itab[i].mret;
            @(negedge clk_i);
            chk($sformatf("idle_ready_%0d", i), 64'(mret_ready_o), 64'(itab[i].exp_ready));
            @(posedge clk_i);
            #1;
            flush_i = 1'b0;
            mret_valid_i = 1'b0;
            @(negedge clk_i);
            chk($sformatf("idle_busy_%0d", i), 64'(busy_o), 64'(itab[i].exp_busy));
        end

        // basic restore, mret_valid held high throughout
        wr0 = wr_cnt;
        csr0 = csr_cnt;
        gnt0 = gnt_cnt;
        run_restore(64'h8000_1000, 1'b1, cyc, first_addr);
        chk("basic_done_cycle", 64'(cyc), 64'd36);
        chk("basic_first_addr", first_addr, 64'h8000_1000);
        chk("basic_gpr_writes", 64'(wr_cnt - wr0), 64'd16);
        chk("basic_csr_writes", 64'(csr_cnt - csr0), 64'd2);
        chk("basic_grants", 64'(gnt_cnt - gnt0), 64'd18);
        chk("no_x0_write", 64'(x0_wr), 64'd0);
        for (int i = 0; i < 18; i++) begin
            if (rtab[i].is_csr)
                chk($sformatf("basic_csr_%0d", rtab[i].idx), csr_got[rtab[i].idx[0]], rtab[i].data);
            else
                chk($sformatf("basic_x%0d", rtab[i].idx), gpr_got[rtab[i].idx], rtab[i].data);
        end

        // backpressure: grant withheld 5 cycles on slot 3
        stall_slot = 3;
        stall_left = 5;
        gnt0 = gnt_cnt;
        run_restore(64'h8000_1000, 1'b0, cyc, first_addr);
        chk("bp_slot3_req_cycles", 64'(s3_cnt), 64'd6);
        chk("bp_slot3_contiguous", 64'(s3_last - s3_first + 1), 64'd6);
        chk("bp_grants", 64'(gnt_cnt - gnt0), 64'd18);
        chk("bp_done_cycle", 64'(cyc), 64'd41);
        stall_slot = -1;

        // flush while waiting on slot 4, response 3 cycles after grant
        lat_slot = 4;
        lat_val = 3;
        wr0 = wr_cnt;
        start_restore(64'h8000_1000);
        find_grant(64'h8000_1020, found);
        chk("flush_grant_seen", 64'(found), 64'd1);
        @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("flush_in_wait_state", 64'(dbg_state_o), 64'd2);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_drain_state", 64'(dbg_state_o), 64'd3);
        chk("flush_pending", 64'(pending_o), 64'd0);
        chk("flush_level", 64'(load_level_o), 64'd0);
        chk("flush_drain_ready", 64'(mret_ready_o), 64'd0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (mem_rvalid_i) begin
                found = 1;
                chk("flush_rvalid_no_gpr_we", 64'(gpr_we_o), 64'd0);
                chk("flush_rvalid_no_csr_we", 64'(csr_we_o), 64'd0);
            end
        end
        chk("flush_rvalid_seen", 64'(found), 64'd1);
        @(negedge clk_i);
        chk("flush_idle_ready", 64'(mret_ready_o), 64'd1);
        chk("flush_idle_state", 64'(dbg_state_o), 64'd0);
        chk("flush_gpr_writes", 64'(wr_cnt - wr0), 64'd2);
        lat_slot = -1;
        lat_val = 1;

        // asynchronous reset while slot 7 is in flight
        wr0 = wr_cnt;
        start_restore(64'h8000_1000);
        find_grant(64'h8000_1038, found);
        chk("rst_grant_seen", 64'(found), 64'd1);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("rst_async_outputs", 64'(any_out), 64'd0);
        @(negedge clk_i);
        chk("rst_partial_writes", 64'(wr_cnt - wr0), 64'd5);
        chk("rst_held_outputs", 64'(any_out), 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        data_base = 64'h200;
        run_restore(64'h8000_2000, 1'b0, cyc, first_addr);
        chk("post_rst_first_addr", first_addr, 64'h8000_2000);
        chk("post_rst_done_cycle", 64'(cyc), 64'd36);
        for (int i = 0; i < 18; i++) begin
            if (rtab[i].is_csr)
                chk($sformatf("post_rst_csr_%0d", rtab[i].idx), csr_got[rtab[i].idx[0]], rtab[i].data + 64'h100);
            else
                chk($sformatf("post_rst_x%0d", rtab[i].idx), gpr_got[rtab[i].idx], rtab[i].data + 64'h100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
